spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
SPI slave that converts serial frames into parallel register-file accesses. It sits between an external SPI master (spi_clk, spi_ss_n, MOSI, MISO) and a 32-register, 32-bit register file. The register file is clocked by the same spi_clk. The bridge decodes a command byte, then issues one register write or one register read per frame.

Parameters:
ADDR_W, 5, register address width (32 registers).
DATA_W, 32, data word width.
CMD_W, 8, command field length in bits.

Ports:
spi_clk  input  1  SPI serial clock. The only clock; toggles only while a frame is active.
rst  input  1  asynchronous, active-high reset.
spi_ss_n  input  1  slave select, active low; frame delimiter.
spi_di  input  1  MOSI, sampled on the rising edge of spi_clk.
spi_do  output  1  MISO, updated on the falling edge of spi_clk.
reg_addr  output  ADDR_W  register address sent to the register file.
cs  output  1  register-file access strobe.
wren  output  1  1 = write, 0 = read; meaningful only while cs=1.
data_in  input  DATA_W  read data from the register file; combinational from reg_addr when cs=1 and wren=0.
data_out  output  DATA_W  write data to the register file.

Behaviour:
SPI mode and frame format
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- Frame = CMD_W command bits followed by DATA_W data bits (40 bits total).
- Command bit 7 = W (1 = write, 0 = read). Bits 6:5 are reserved and ignored. Bits 4:0 = address.

Reset and idle
- rst=1 or spi_ss_n=1 asynchronously clears the bit counter, FSM and strobes: state=IDLE, cs=0, wren=0, spi_do=0.
- reg_addr and data_out clear to 0 on rst only; they hold their values across spi_ss_n deassertion.
- spi_do is driven 0 (never tri-stated) outside the read data phase.

FSM states: IDLE, CMD, DATA, COMMIT.
- IDLE -> CMD on the first rising edge with spi_ss_n=0.
- CMD: shift spi_di in. On rising edge 8, latch reg_addr and the W bit, then go to DATA.
  - If W=0 (read): cs=1 and wren=0 from edge 8 until the frame ends.
- DATA, write: shift 32 bits into data_out's shift register. On rising edge 40, present data_out and go to COMMIT with cs=1, wren=1.
  - The register file captures the data on the next rising edge (edge 41). The bridge then clears cs and wren and returns to IDLE.
  - A write frame therefore needs 41 spi_clk cycles with spi_ss_n held low.
- DATA, read: on the falling edge after edge 8, load data_in into the TX shift register and drive bit 31 onto spi_do.
  - Each following falling edge shifts the next bit out. The master samples bit 31 at edge 9 and bit 0 at edge 40.
  - After edge 40, cs drops and the FSM returns to IDLE.
- Bits received on MOSI during the read data phase are ignored.

Boundary conditions
- spi_ss_n rising mid-frame aborts the frame. No write occurs and no register changes.
- Extra clocks beyond 41 while spi_ss_n is still low start a new frame.
- Reserved command bits have no effect.
- All address values 0–31 are valid; there is no address-overflow output.

Decomposition:
- Shared package spi_reg_pkg holds:
  - ADDR_W, DATA_W, CMD_W
  - bit positions CMD_W_BIT=7 and CMD_ADDR_MSB=4
  - FSM state enum (IDLE, CMD, DATA, COMMIT)
  - frame length constants READ_LEN=40 and WRITE_LEN=41
- One natural sub-module: spi_shift_io, containing the RX shift register (rising edge) and the TX shift register (falling edge, parallel load). The FSM and strobe logic stay in the top level.

Test Plan:
- Reset: assert rst with spi_ss_n=1 -> cs=0, wren=0, spi_do=0, reg_addr=0, data_out=0.
- Write: frame 0x83 then 0xDEADBEEF, 41 clocks -> reg_addr=3 and data_out=0xDEADBEEF; cs=1 and wren=1 for exactly one cycle; register 3 = 0xDEADBEEF.
- Read-back: frame 0x03 plus 32 dummy bits -> cs=1 and wren=0 from edge 8; MISO returns 0xDEADBEEF MSB first, sampled on rising edges 9–40.
- Address extremes: write 0x12345678 to address 0 (cmd 0x80) and 0xA5A5A5A5 to address 31 (cmd 0x9F), then read both -> exact values returned, no aliasing.
- Abort: write frame to address 5 with spi_ss_n raised after 20 clocks -> no cs pulse; register 5 unchanged; next full frame works normally.
- Reserved bits: command 0xE3 (reserved bits set) with data 0x0000FFFF -> behaves as a write to address 3.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared constants, frame geometry and FSM state type for the SPI-to-register bridge.
package spi_reg_pkg;
  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 32;
  localparam int CMD_W        = 8;
  localparam int CMD_W_BIT    = 7;
  localparam int CMD_ADDR_MSB = 4;
  localparam int READ_LEN     = CMD_W + DATA_W;
  localparam int WRITE_LEN    = READ_LEN + 1;
  localparam int CNT_W        = $clog2(WRITE_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    COMMIT
  } state_e;
endpackage

// File: rtl/spi_shift_io.sv
// Serial datapath: MOSI shift register on the rising edge, MISO shift register on the falling edge.
module spi_shift_io
  import spi_reg_pkg::*;
(
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              di_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] par_i,
  output logic [DATA_W-1:0] rx_next_o,
  output logic              do_o
);
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] tx_q, tx_d;

  assign rx_next_o = {rx_q[DATA_W-2:0], di_i};

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) rx_q <= '0;
    else        rx_q <= rx_next_o;
  end

  // Outside the read data phase the TX register empties, so MISO idles low.
  always_comb begin
    tx_d = '0;
    if (load_i)       tx_d = par_i;
    else if (shift_i) tx_d = {tx_q[DATA_W-2:0], 1'b0};
  end

  always_ff @(negedge clk_i or posedge arst_i) begin
    if (arst_i) tx_q <= '0;
    else        tx_q <= tx_d;
  end

  assign do_o = tx_q[DATA_W-1];
endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns each 40/41-clock frame into one register-file read or write.
module spi_reg_bridge
  import spi_reg_pkg::*;
(
  input  logic              spi_clk,
  input  logic              rst,
  input  logic              spi_ss_n,
  input  logic              spi_di,
  output logic              spi_do,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              cs,
  output logic              wren,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);
  logic              frame_rst;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic              cs_q, cs_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rx_next;
  logic              rd_phase;

  // Deselect aborts the frame immediately; address and write data survive it.
  assign frame_rst = rst | spi_ss_n;
  assign rd_phase  = (state_q == DATA) && !write_q;

  spi_shift_io u_shift_io (
    .clk_i     (spi_clk),
    .arst_i    (frame_rst),
    .di_i      (spi_di),
    .load_i    (rd_phase && (cnt_q == CNT_W'(CMD_W))),
    .shift_i   (rd_phase),
    .par_i     (data_in),
    .rx_next_o (rx_next),
    .do_o      (spi_do)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    write_d = write_q;
    cs_d    = cs_q;
    wren_d  = wren_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        state_d = CMD;
        cnt_d   = CNT_W'(1);
      end
      CMD: begin
        if (cnt_q == CNT_W'(CMD_W - 1)) begin
          state_d = DATA;
          write_d = rx_next[CMD_W_BIT];
          addr_d  = rx_next[CMD_ADDR_MSB:0];
          cs_d    = ~rx_next[CMD_W_BIT];
          wren_d  = 1'b0;
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(READ_LEN - 1)) begin
          if (write_q) begin
            state_d = COMMIT;
            dout_d  = rx_next;
            cs_d    = 1'b1;
            wren_d  = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            cs_d    = 1'b0;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        cnt_d   = '0;
        cs_d    = 1'b0;
        wren_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge spi_clk or posedge frame_rst) begin
    if (frame_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      cs_q    <= 1'b0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      cs_q    <= cs_d;
      wren_q  <= wren_d;
    end
  end

  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      dout_q <= '0;
    end else begin
      addr_q <= addr_d;
      dout_q <= dout_d;
    end
  end

  assign reg_addr = addr_q;
  assign data_out = dout_q;
  assign cs       = cs_q;
  assign wren     = wren_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Drives SPI frames into the bridge with an attached register file and checks every cycle against a frame-level model.
module tb_spi_reg_bridge;
  logic        spi_clk = 1'b0;
  logic        rst;
  logic        spi_ss_n;
  logic        spi_di;
  logic        spi_do;
  logic [4:0]  reg_addr;
  logic        cs;
  logic        wren;
  logic [31:0] data_in;
  logic [31:0] data_out;

  logic [31:0] rf [32];

  int checks = 0;
  int errors = 0;

  // Current frame as seen by the model.
  int          edge_k = 0;
  logic [7:0]  f_cmd  = 8'h00;
  logic [31:0] f_data = 32'h0;
  logic [31:0] miso_word = 32'h0;

  // Model state: what the register file and bridge outputs must hold.
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_dout = 32'h0;
  logic [31:0] m_mem [32] = '{default: 32'h0};

  spi_reg_bridge dut (
    .spi_clk  (spi_clk),
    .rst      (rst),
    .spi_ss_n (spi_ss_n),
    .spi_di   (spi_di),
    .spi_do   (spi_do),
    .reg_addr (reg_addr),
    .cs       (cs),
    .wren     (wren),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (cs && wren) begin
      rf[reg_addr] <= data_out;
    end
  end

  assign data_in = (cs && !wren) ? rf[reg_addr] : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // After rising edge k of a frame and its following falling edge, outputs must match the frame rules.
  always @(negedge spi_clk) begin : compare
    logic       wr;
    logic [4:0] a;
    logic       exp_cs;
    logic       exp_wren;
    logic       exp_do;
    #2;
    wr = f_cmd[7];
    a  = f_cmd[4:0];
    if (edge_k == 8) m_addr = a;
    if (wr && edge_k == 40) m_dout = f_data;
    if (wr && edge_k == 41) m_mem[a] = f_data;
    exp_cs   = wr ? (edge_k == 40) : (edge_k >= 8 && edge_k <= 39);
    exp_wren = wr && (edge_k == 40);
    exp_do   = (!wr && edge_k >= 8 && edge_k <= 39) ? m_mem[a][39 - edge_k] : 1'b0;
    chk("cyc_cs",       {31'h0, cs},     {31'h0, exp_cs});
    chk("cyc_wren",     {31'h0, wren},   {31'h0, exp_wren});
    chk("cyc_spi_do",   {31'h0, spi_do}, {31'h0, exp_do});
    chk("cyc_reg_addr", {27'h0, reg_addr}, {27'h0, m_addr});
    chk("cyc_data_out", data_out, m_dout);
  end

  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] data, input int nclk);
    logic [39:0] bits;
    bits      = {cmd, data};
    f_cmd     = cmd;
    f_data    = data;
    edge_k    = 0;
    miso_word = 32'h0;
    for (int i = 0; i < nclk; i++) begin
      spi_di = (i < 40) ? bits[39 - i] : 1'b0;
      #3;
      if (i >= 8 && i < 40) miso_word = {miso_word[30:0], spi_do};
      #2 spi_clk = 1'b1;
      edge_k = edge_k + 1;
      #5 spi_clk = 1'b0;
      #5;
    end
    $display("frame cmd=%h data=%h clocks=%0d miso=%h", cmd, data, nclk, miso_word);
  endtask

  task automatic select_slave();
    spi_ss_n = 1'b0;
    #5;
  endtask

  task automatic deselect_slave();
    spi_ss_n = 1'b1;
    #5;
    chk("idle_cs",       {31'h0, cs},     32'h0);
    chk("idle_wren",     {31'h0, wren},   32'h0);
    chk("idle_spi_do",   {31'h0, spi_do}, 32'h0);
    chk("idle_reg_addr", {27'h0, reg_addr}, {27'h0, m_addr});
    chk("idle_data_out", data_out, m_dout);
  endtask

  task automatic do_write(input logic [7:0] cmd, input logic [31:0] data);
    select_slave();
    run_frame(cmd, data, 41);
    deselect_slave();
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [31:0] exp);
    select_slave();
    run_frame(cmd, 32'hFFFF0000, 40);
    deselect_slave();
    chk("miso_word", miso_word, exp);
  endtask

  initial begin
    rst      = 1'b1;
    spi_ss_n = 1'b1;
    spi_di   = 1'b0;
    #10;
    chk("rst_cs",       {31'h0, cs},     32'h0);
    chk("rst_wren",     {31'h0, wren},   32'h0);
    chk("rst_spi_do",   {31'h0, spi_do}, 32'h0);
    chk("rst_reg_addr", {27'h0, reg_addr}, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    rst = 1'b0;
    #5;

    do_write(8'h83, 32'hDEADBEEF);
    chk("rf3_write", rf[3], 32'hDEADBEEF);
    do_read(8'h03, 32'hDEADBEEF);

    do_write(8'h80, 32'h12345678);
    do_write(8'h9F, 32'hA5A5A5A5);
    do_read(8'h00, 32'h12345678);
    do_read(8'h1F, 32'hA5A5A5A5);
    do_read(8'h03, 32'hDEADBEEF);
    chk("rf0_write", rf[0], 32'h12345678);
    chk("rf31_write", rf[31], 32'hA5A5A5A5);

    select_slave();
    run_frame(8'h85, 32'hCAFEF00D, 20);
    deselect_slave();
    chk("abort_rf5", rf[5], 32'h0);
    chk("abort_reg_addr", {27'h0, reg_addr}, 32'd5);
    chk("abort_data_out", data_out, 32'hA5A5A5A5);
    do_read(8'h05, 32'h0);
    do_write(8'h85, 32'h0BADF00D);
    do_read(8'h05, 32'h0BADF00D);

    do_write(8'hE3, 32'h0000FFFF);
    chk("rsvd_rf3", rf[3], 32'h0000FFFF);
    do_read(8'h03, 32'h0000FFFF);

    select_slave();
    run_frame(8'h8A, 32'h600DCAFE, 41);
    run_frame(8'h0A, 32'hFFFF0000, 40);
    deselect_slave();
    chk("b2b_miso", miso_word, 32'h600DCAFE);
    chk("b2b_rf10", rf[10], 32'h600DCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
